// File: rtl/sprite_rom_arbiter_if.sv
// Bundle of the requester, ROM and read-return signals around the sprite ROM arbiter.
// slave = arbiter side, master = renderers plus the shared ROM.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                      blank;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q;
  logic                      rd_valid;
  logic [ID_W-1:0]           rd_id;
  logic [DATA_W-1:0]         rd_data;

  modport slave (
    input  blank, req, req_addr, rom_q,
    output gnt, rom_address, rd_valid, rd_id, rd_data
  );

  modport master (
    output blank, req, req_addr, rom_q,
    input  gnt, rom_address, rd_valid, rd_id, rd_data
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM port among NUM_REQ renderers, one grant per cycle.
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module sprite_rom_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 8,
  parameter int ROM_LATENCY = 0
) (
  input  logic                vga_clk_i,
  input  logic                reset_i,
  sprite_rom_arbiter_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = ROM_LATENCY + 1;

  logic [NUM_REQ-1:0] gnt_d;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [ADDR_W-1:0]  rom_address_q;
  logic               tag_vld_q [DEPTH];
  logic [ID_W-1:0]    tag_id_q  [DEPTH];
  logic               rd_valid_q;
  logic [ID_W-1:0]    rd_id_q;
  logic [DATA_W-1:0]  rd_data_q;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    ptr_d;
`endif

  // Scanning from the far end down lets the closest candidate overwrite the rest.
  always_comb begin
    gnt_idx = '0;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[ID_W'(i)]) gnt_idx = ID_W'(i);
    end
`else
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int cand;
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (bus.req[ID_W'(cand)]) gnt_idx = ID_W'(cand);
    end
    ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
`endif
    gnt_any = bus.blank && !reset_i && (|bus.req);
    gnt_d   = '0;
    if (gnt_any) gnt_d[gnt_idx] = 1'b1;
  end

  always_ff @(posedge vga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      rom_address_q <= '0;
      rd_valid_q    <= 1'b0;
      rd_id_q       <= '0;
      rd_data_q     <= '0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
      ptr_q         <= '0;
`endif
      for (int s = 0; s < DEPTH; s++) begin
        tag_vld_q[s] <= 1'b0;
        tag_id_q[s]  <= '0;
      end
    end else begin
      // Address holds when idle so the ROM sees no spurious toggle.
      if (gnt_any) begin
        rom_address_q <= bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
`ifndef SPRITE_ARB_FIXED_PRIO_EN
        ptr_q         <= ptr_d;
`endif
      end
      tag_vld_q[0] <= gnt_any;
      tag_id_q[0]  <= gnt_idx;
      for (int s = 1; s < DEPTH; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
      rd_valid_q <= tag_vld_q[DEPTH-1];
      rd_id_q    <= tag_id_q[DEPTH-1];
      rd_data_q  <= bus.rom_q;
    end
  end

  assign bus.gnt         = gnt_d;
  assign bus.rom_address = rom_address_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_id       = rd_id_q;
  assign bus.rd_data     = rd_data_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: three instances at ROM latency 0, 1 and 3
// share one stimulus stream; each has its own ROM model returning address[7:0].
`timescale 1ns/1ps
module tb_sprite_rom_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_l0 ();
  sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_l1 ();
  sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_l3 ();

  sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LATENCY(0))
    u_dut_l0 (.vga_clk_i(clk), .reset_i(rst), .bus(bus_l0));
  sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LATENCY(1))
    u_dut_l1 (.vga_clk_i(clk), .reset_i(rst), .bus(bus_l1));
  sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LATENCY(3))
    u_dut_l3 (.vga_clk_i(clk), .reset_i(rst), .bus(bus_l3));

  assign bus_l0.blank    = bus_l1.blank;
  assign bus_l0.req      = bus_l1.req;
  assign bus_l0.req_addr = bus_l1.req_addr;
  assign bus_l3.blank    = bus_l1.blank;
  assign bus_l3.req      = bus_l1.req;
  assign bus_l3.req_addr = bus_l1.req_addr;

  // ROM models: data = address[7:0], valid ROM_LATENCY cycles after the address changes.
  logic [7:0] rom3_p1, rom3_p2;
  always @(negedge clk) bus_l0.rom_q <= bus_l0.rom_address[7:0];
  always @(posedge clk) bus_l1.rom_q <= bus_l1.rom_address[7:0];
  always @(posedge clk) begin
    rom3_p1      <= bus_l3.rom_address[7:0];
    rom3_p2      <= rom3_p1;
    bus_l3.rom_q <= rom3_p2;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic v, input logic [1:0] id, input logic [7:0] d,
                        input logic ev, input logic [1:0] eid, input logic [7:0] ed);
    chk({tag, "_vld"}, 32'(v), 32'(ev));
    if (ev) begin
      chk({tag, "_id"}, 32'(id), 32'(eid));
      chk({tag, "_data"}, 32'(d), 32'(ed));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-requester addresses used in the round-robin, blank and reset phases.
  localparam logic [35:0] RR_ADDRS = {9'h1D9, 9'h1C6, 9'h1B3, 9'h1A0};
  logic [7:0] rr_data [4] = '{8'hA0, 8'hB3, 8'hC6, 8'hD9};
`ifdef SPRITE_ARB_FIXED_PRIO_EN
  logic [1:0] rr_id [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
  logic [1:0] bl_id3 = 2'd0;
`else
  logic [1:0] rr_id [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] bl_id3 = 2'd1;
`endif
  logic [1:0] bl_gnt [4];
  logic [1:0] bl_blank [4] = '{2'd1, 2'd0, 2'd0, 2'd1};
  logic [8:0] sw_addr [6] = '{9'h0F0, 9'h0F7, 9'h0FE, 9'h105, 9'h10C, 9'h113};
  logic [7:0] sw_data [6] = '{8'hF0, 8'hF7, 8'hFE, 8'h05, 8'h0C, 8'h13};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int j0, j1, j3;
    logic [3:0] eg;

    rst = 1'b1;
    bus_l1.blank    = 1'b0;
    bus_l1.req      = '0;
    bus_l1.req_addr = '0;
    repeat (4) @(posedge clk);
    #1;
    // Grants must stay off while reset is held even with every request up.
    bus_l1.blank = 1'b1;
    bus_l1.req   = 4'hF;
    #1;
    chk("rst_gnt", 32'(bus_l1.gnt), 32'd0);
    chk("rst_addr", 32'(bus_l1.rom_address), 32'd0);
    chk_rd("rst_l1", bus_l1.rd_valid, bus_l1.rd_id, bus_l1.rd_data, 1'b1 && 1'b0, 2'd0, 8'd0);
    chk("rst_id", 32'(bus_l1.rd_id), 32'd0);
    chk("rst_data", 32'(bus_l1.rd_data), 32'd0);
    bus_l1.req = '0;
    rst = 1'b0;

    // Round-robin: all four request for 8 cycles.
    bus_l1.req_addr = RR_ADDRS;
    for (int c = 0; c < 13; c++) begin
      step();
      bus_l1.req = (c < 8) ? 4'hF : 4'h0;
      #1;
      eg = (c < 8) ? (4'b0001 << rr_id[c % 8]) : 4'b0000;
      chk("rr_gnt", 32'(bus_l1.gnt), 32'(eg));
      j0 = c - 2; j1 = c - 3; j3 = c - 5;
      chk_rd("rr_l0", bus_l0.rd_valid, bus_l0.rd_id, bus_l0.rd_data,
             j0 >= 0 && j0 < 8, rr_id[j0 & 7], rr_data[rr_id[j0 & 7]]);
      chk_rd("rr_l1", bus_l1.rd_valid, bus_l1.rd_id, bus_l1.rd_data,
             j1 >= 0 && j1 < 8, rr_id[j1 & 7], rr_data[rr_id[j1 & 7]]);
      chk_rd("rr_l3", bus_l3.rd_valid, bus_l3.rd_id, bus_l3.rd_data,
             j3 >= 0 && j3 < 8, rr_id[j3 & 7], rr_data[rr_id[j3 & 7]]);
    end

    // Single read from requester 2 at 0x05A.
    step();
    bus_l1.req      = 4'b0100;
    bus_l1.req_addr = {9'h000, 9'h05A, 9'h000, 9'h000};
    #1;
    chk("single_gnt", 32'(bus_l1.gnt), 32'h4);
    step();
    bus_l1.req = 4'b0000;
    #1;
    chk("single_addr", 32'(bus_l1.rom_address), 32'h05A);
    chk("single_gnt_idle", 32'(bus_l1.gnt), 32'd0);
    for (int c = 2; c < 7; c++) begin
      step();
      #1;
      chk_rd("single_l0", bus_l0.rd_valid, bus_l0.rd_id, bus_l0.rd_data, c == 2, 2'd2, 8'h5A);
      chk_rd("single_l1", bus_l1.rd_valid, bus_l1.rd_id, bus_l1.rd_data, c == 3, 2'd2, 8'h5A);
      chk_rd("single_l3", bus_l3.rd_valid, bus_l3.rd_id, bus_l3.rd_data, c == 5, 2'd2, 8'h5A);
    end

    // Blank gating with requesters 0 and 1; the pointer sits at 3 going in.
    bl_gnt = '{2'b01, 2'b00, 2'b00, (bl_id3 == 2'd1) ? 2'b10 : 2'b01};
    bus_l1.req_addr = RR_ADDRS;
    for (int c = 0; c < 10; c++) begin
      step();
      bus_l1.req   = (c < 4) ? 4'b0011 : 4'b0000;
      bus_l1.blank = (c < 4) ? bl_blank[c][0] : 1'b1;
      #1;
      chk("blank_gnt", 32'(bus_l1.gnt), (c < 4) ? 32'(bl_gnt[c]) : 32'd0);
      if (c == 1 || c == 2) chk("blank_addr_hold", 32'(bus_l1.rom_address), 32'h1A0);
      j0 = c - 2; j1 = c - 3; j3 = c - 5;
      chk_rd("blank_l0", bus_l0.rd_valid, bus_l0.rd_id, bus_l0.rd_data, j0 == 0 || j0 == 3,
             (j0 == 0) ? 2'd0 : bl_id3, (j0 == 0) ? 8'hA0 : rr_data[bl_id3]);
      chk_rd("blank_l1", bus_l1.rd_valid, bus_l1.rd_id, bus_l1.rd_data, j1 == 0 || j1 == 3,
             (j1 == 0) ? 2'd0 : bl_id3, (j1 == 0) ? 8'hA0 : rr_data[bl_id3]);
      chk_rd("blank_l3", bus_l3.rd_valid, bus_l3.rd_id, bus_l3.rd_data, j3 == 0 || j3 == 3,
             (j3 == 0) ? 2'd0 : bl_id3, (j3 == 0) ? 8'hA0 : rr_data[bl_id3]);
    end

    // Latency sweep: back-to-back grants alternating between requesters 0 and 1.
    for (int c = 0; c < 12; c++) begin
      step();
      bus_l1.req      = (c < 6) ? ((c % 2 == 0) ? 4'b0001 : 4'b0010) : 4'b0000;
      bus_l1.req_addr = {9'h000, 9'h000, sw_addr[c % 6], sw_addr[c % 6]};
      #1;
      chk("sweep_gnt", 32'(bus_l1.gnt), 32'(bus_l1.req));
      j0 = c - 2; j1 = c - 3; j3 = c - 5;
      chk_rd("sweep_l0", bus_l0.rd_valid, bus_l0.rd_id, bus_l0.rd_data,
             j0 >= 0 && j0 < 6, 2'(j0 & 1), sw_data[(j0 + 6) % 6]);
      chk_rd("sweep_l1", bus_l1.rd_valid, bus_l1.rd_id, bus_l1.rd_data,
             j1 >= 0 && j1 < 6, 2'(j1 & 1), sw_data[(j1 + 6) % 6]);
      chk_rd("sweep_l3", bus_l3.rd_valid, bus_l3.rd_id, bus_l3.rd_data,
             j3 >= 0 && j3 < 6, 2'(j3 & 1), sw_data[(j3 + 6) % 6]);
    end

    // Reset mid-stream with three reads in flight on the latency-1 instance.
    bus_l1.req_addr = RR_ADDRS;
    for (int c = 0; c < 3; c++) begin
      step();
      bus_l1.req = 4'hF;
      #1;
    end
    step();
    bus_l1.req = 4'h0;
    #1;
    chk("mid_vld_before", 32'(bus_l1.rd_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_addr", 32'(bus_l1.rom_address), 32'd0);
    chk("mid_vld", 32'(bus_l1.rd_valid), 32'd0);
    chk("mid_id", 32'(bus_l1.rd_id), 32'd0);
    chk("mid_data", 32'(bus_l1.rd_data), 32'd0);
    chk("mid_vld_l0", 32'(bus_l0.rd_valid), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      #1;
      chk("post_vld_l0", 32'(bus_l0.rd_valid), 32'd0);
      chk("post_vld_l1", 32'(bus_l1.rd_valid), 32'd0);
      chk("post_vld_l3", 32'(bus_l3.rd_valid), 32'd0);
    end
    step();
    bus_l1.req = 4'hF;
    #1;
    chk("post_first_gnt", 32'(bus_l1.gnt), 32'h1);
    step();
    bus_l1.req = 4'h0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous sprite ROM read port among `NUM_REQ` sprite renderers on the VGA pixel clock. It grants one request per cycle with round-robin priority and drives the ROM address. It tracks in-flight reads in a latency-matched tag pipeline and returns each ROM byte with the ID of the requester that issued it. It sits between the per-sprite address generators and a single shared `*_rom` instance; palette lookup stays downstream of `rd_data`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 9: ROM address width.
- `DATA_W`, 8: ROM word width (palette index).
- `ROM_LATENCY`, 0: vga_clk cycles from a `rom_address` change to a valid `rom_q`, 0..3. 0 means a negedge-clocked ROM.
- Derived `ID_W` = max(1, clog2(NUM_REQ)).

Ports:
- `vga_clk`  in  1  pixel clock; all logic is on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `blank`  in  1  1 = active display. Grants are issued only while it is high.
- `req`  in  NUM_REQ  per-requester read request.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- `gnt`  out  NUM_REQ  one-hot combinational grant, valid in the same cycle as `req`.
- `rom_address`  out  ADDR_W  registered ROM address.
- `rom_q`  in  DATA_W  ROM read data.
- `rd_valid`  out  1  returned data valid.
- `rd_id`  out  ID_W  requester ID for `rd_data`.
- `rd_data`  out  DATA_W  registered ROM data.

## Operation
- **Request handshake**
  - A requester holds `req[i]` high and `req_addr` stable until it samples `gnt[i]` high on a rising edge.
  - Transfer happens when `req[i] & gnt[i]` on an edge.
  - The requester may drop `req` or present a new address in the following cycle.
- **Grant rule**
  - `gnt` is all zero when `blank` = 0 or `req` = 0.
  - Otherwise exactly one bit is set: the first requesting index scanning `ptr`, `ptr+1`, … with wrap modulo `NUM_REQ`.
- **Pointer**
  - `ptr` resets to 0.
  - On any grant to index g, `ptr` <= (g+1) mod `NUM_REQ`.
  - Otherwise `ptr` is unchanged.
- **Address register**
  - On a grant, `rom_address` <= the granted `req_addr` slice.
  - Otherwise it holds its value. This avoids a spurious ROM toggle and makes no read.
- **Tag pipeline**
  - A shift register of depth `ROM_LATENCY`+1 carries {valid, id}.
  - Stage 0 captures {|gnt, granted index} each edge.
  - The final stage feeds the output register.
- **Output register**
  - Each edge: `rd_valid` <= last-stage valid, `rd_id` <= last-stage id, `rd_data` <= `rom_q`.
  - `rd_data` is don't-care when `rd_valid` = 0. It still updates, with no gating required.
- **Blank**
  - A falling `blank` stops new grants only.
  - Reads already in flight complete and are returned normally.

## Timing
- **Reset values** (asynchronous on `Reset` high): `rom_address` = 0, `rd_valid` = 0, `rd_id` = 0, `rd_data` = 0, `ptr` = 0, all tag valids = 0.
- `gnt` is combinational and forced to 0 while `Reset` is high.
- **Latency**, for a grant in cycle t (edge E at the end of t):
  - `rom_address` is valid in t+1.
  - `rom_q` is sampled at the end of t+1+`ROM_LATENCY`.
  - `rd_valid`/`rd_id`/`rd_data` are valid in t+2+`ROM_LATENCY`, for exactly one cycle.
- **Throughput**: one grant and one return per cycle, fully pipelined, no stalls, no backpressure on the return side.
- **Simultaneous events**
  - Requests from all requesters in the same cycle are served over `NUM_REQ` consecutive cycles in rotating order.
  - A requester that re-requests immediately after its grant waits behind all others.
- **Reset mid-operation**: all in-flight reads are discarded. No `rd_valid` pulse follows the deassertion of `Reset` unless a new grant occurs.
- **Wrap**: `ptr` at `NUM_REQ`-1 with a grant to index `NUM_REQ`-1 returns to 0.

## Configuration
- **`SPRITE_ARB_FIXED_PRIO_EN`**
  - Defined: fixed priority. The lowest requesting index always wins, `ptr` is not implemented, and the ordering rule in Simultaneous events does not apply.
  - Undefined (default): round-robin as specified above.
  - Handshake, latency and all output timing are identical in both builds.

## Test plan
- **Reset:** assert `Reset` mid-stream, with 3 reads in flight (`ROM_LATENCY`=1). Required: all outputs 0 immediately; no `rd_valid` after release; first grant after release goes to req 0.
- **Single read:** `req`=4'b0100, addr 0x05A, `blank`=1, ROM model returns addr[7:0]. Required: `gnt`=4'b0100 in cycle t; `rom_address`=0x05A in t+1; `rd_valid`=1, `rd_id`=2, `rd_data`=0x5A in t+3.
- **Round-robin:** `req`=4'b1111 held for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3; `rd_id` sequence is identical, shifted by 2+`ROM_LATENCY` cycles. With `SPRITE_ARB_FIXED_PRIO_EN`: 8 grants to 0.
- **Blank gating:** `req`=4'b0011 while `blank` toggles 1,0,0,1. Required: `gnt` is 0 in both `blank`=0 cycles; in-flight data is still returned; `ptr` is unchanged across the gap.
- **Latency sweep:** `ROM_LATENCY`=0 and 3, with back-to-back grants to alternating requesters. Required: `rd_valid` is continuous with no gaps; `rd_data`/`rd_id` match per-grant addresses at t+2 and t+5 respectively.
